maxpool_ctrl: RTL and testbench

Sequencer for 2x2 max-pooling over a feature map stored in a single-port, shared byte SRAM. On `start` it walks the map in non-overlapping 2x2 windows and fetches the four bytes of each window through a granted read port. It reduces each window with an internal instance of the team's 2x2 max comparator (MaxOf4) and writes one byte per window to a contiguous output buffer. It sits between the SoC register block (base addresses, dimensions, start/done) and the SRAM arbiter.

---
 rtl/maxpool_ctrl_if.sv | 31 +++
 rtl/maxpool_ctrl.sv | 173 +++++++++++++++++
 tb/tb_maxpool_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/maxpool_ctrl_if.sv
// Bundle of the maxpool_ctrl control, SRAM-read and result-write signals.
// master: the pooling sequencer; slave: register block, arbiter and SRAM side.
interface maxpool_ctrl_if #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned DIM_W  = 8
);
   logic              start;
   logic [ADDR_W-1:0] in_base;
   logic [ADDR_W-1:0] out_base;
   logic [DIM_W-1:0]  map_w;
   logic [DIM_W-1:0]  map_h;
   logic              rd_req;
   logic              rd_gnt;
   logic [ADDR_W-1:0] rd_addr;
   logic [7:0]        rd_data;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              busy;
   logic              done;

   modport master (
      input  start, in_base, out_base, map_w, map_h, rd_gnt, rd_data,
      output rd_req, rd_addr, wr_en, wr_addr, wr_data, busy, done
   );

   modport slave (
      output start, in_base, out_base, map_w, map_h, rd_gnt, rd_data,
      input  rd_req, rd_addr, wr_en, wr_addr, wr_data, busy, done
   );
endinterface

// File: rtl/maxpool_ctrl.sv
// 2x2 max-pooling sequencer over a shared byte SRAM, one result byte per window.
// Optional macro MAXPOOL_RELU_EN: results with bit 7 set are written as 0x00.
module maxpool_ctrl #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned DIM_W  = 8
) (
   input logic           clk,
   input logic           RSTn,
   maxpool_ctrl_if.master bus
);
   localparam logic [2:0] StIdle = 3'd0;
   localparam logic [2:0] StRd0  = 3'd1;
   localparam logic [2:0] StRd1  = 3'd2;
   localparam logic [2:0] StRd2  = 3'd3;
   localparam logic [2:0] StRd3  = 3'd4;
   localparam logic [2:0] StCap  = 3'd5;
   localparam logic [2:0] StWr   = 3'd6;
   localparam logic [2:0] StFin  = 3'd7;

   localparam int unsigned OffW = (2 * DIM_W > ADDR_W) ? 2 * DIM_W : ADDR_W;

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] in_base_q, in_base_d;
   logic [ADDR_W-1:0] out_base_q, out_base_d;
   logic [ADDR_W-1:0] k_q, k_d;
   logic [DIM_W-1:0]  map_w_q, map_w_d;
   logic [DIM_W-1:0]  map_h_q, map_h_d;
   logic [DIM_W-1:0]  r_q, r_d;
   logic [DIM_W-1:0]  c_q, c_d;
   logic [7:0]        d00_q, d01_q, d10_q, d11_q;
   logic              issue_q;
   logic [1:0]        issue_idx_q;

   logic              rd_req;
   logic              issue;
   logic [1:0]        rd_idx;
   logic [OffW-1:0]   offs;
   logic [DIM_W:0]    c_nxt, r_nxt;
   logic [7:0]        m0, m1, max4, result;

   // rd_idx bit 0 selects the right column, bit 1 the lower row of the window
   always_comb begin
      rd_req = 1'b0;
      rd_idx = 2'd0;
      case (state_q)
         StRd0: begin rd_req = 1'b1; rd_idx = 2'd0; end
         StRd1: begin rd_req = 1'b1; rd_idx = 2'd1; end
         StRd2: begin rd_req = 1'b1; rd_idx = 2'd2; end
         StRd3: begin rd_req = 1'b1; rd_idx = 2'd3; end
         default: ;
      endcase
   end

   assign issue = rd_req & bus.rd_gnt;
   assign offs  = (OffW'(r_q) + OffW'(rd_idx[1])) * OffW'(map_w_q)
                + OffW'(c_q) + OffW'(rd_idx[0]);

   // MaxOf4: row pairs compared on the low 7 bits, then a full 8-bit compare
   assign m0   = (d00_q[6:0] > d01_q[6:0]) ? d00_q : d01_q;
   assign m1   = (d10_q[6:0] > d11_q[6:0]) ? d10_q : d11_q;
   assign max4 = (m0 > m1) ? m0 : m1;

`ifdef MAXPOOL_RELU_EN
   assign result = max4[7] ? 8'h00 : max4;
`else
   assign result = max4;
`endif

   assign bus.rd_req  = rd_req;
   assign bus.rd_addr = rd_req ? (in_base_q + offs[ADDR_W-1:0]) : '0;
   assign bus.wr_en   = (state_q == StWr);
   assign bus.wr_addr = (state_q == StWr) ? (out_base_q + k_q) : '0;
   assign bus.wr_data = (state_q == StWr) ? result : 8'h00;
   assign bus.busy    = (state_q != StIdle) && (state_q != StFin);
   assign bus.done    = (state_q == StFin);

   assign c_nxt = {1'b0, c_q} + (DIM_W+1)'(2);
   assign r_nxt = {1'b0, r_q} + (DIM_W+1)'(2);

   always_comb begin
      state_d    = state_q;
      in_base_d  = in_base_q;
      out_base_d = out_base_q;
      map_w_d    = map_w_q;
      map_h_d    = map_h_q;
      r_d        = r_q;
      c_d        = c_q;
      k_d        = k_q;
      case (state_q)
         StIdle: begin
            if (bus.start) begin
               in_base_d  = bus.in_base;
               out_base_d = bus.out_base;
               map_w_d    = bus.map_w;
               map_h_d    = bus.map_h;
               r_d        = '0;
               c_d        = '0;
               k_d        = '0;
               if (bus.map_w[DIM_W-1:1] == '0 || bus.map_h[DIM_W-1:1] == '0) begin
                  state_d = StFin;
               end else begin
                  state_d = StRd0;
               end
            end
         end
         StRd0: if (issue) state_d = StRd1;
         StRd1: if (issue) state_d = StRd2;
         StRd2: if (issue) state_d = StRd3;
         StRd3: if (issue) state_d = StCap;
         StCap: if (issue_q) state_d = StWr;
         StWr: begin
            k_d = k_q + ADDR_W'(1);
            if (c_nxt + (DIM_W+1)'(1) >= {1'b0, map_w_q}) begin
               c_d = '0;
               r_d = r_nxt[DIM_W-1:0];
               if (r_nxt + (DIM_W+1)'(1) >= {1'b0, map_h_q}) begin
                  state_d = StFin;
               end else begin
                  state_d = StRd0;
               end
            end else begin
               c_d     = c_nxt[DIM_W-1:0];
               state_d = StRd0;
            end
         end
         StFin:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         state_q     <= StIdle;
         in_base_q   <= '0;
         out_base_q  <= '0;
         map_w_q     <= '0;
         map_h_q     <= '0;
         r_q         <= '0;
         c_q         <= '0;
         k_q         <= '0;
         issue_q     <= 1'b0;
         issue_idx_q <= 2'd0;
      end else begin
         state_q     <= state_d;
         in_base_q   <= in_base_d;
         out_base_q  <= out_base_d;
         map_w_q     <= map_w_d;
         map_h_q     <= map_h_d;
         r_q         <= r_d;
         c_q         <= c_d;
         k_q         <= k_d;
         issue_q     <= issue;
         issue_idx_q <= rd_idx;
      end
   end

   // Read data arrives one cycle after issue; the registered index steers it
   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         d00_q <= 8'h00;
         d01_q <= 8'h00;
         d10_q <= 8'h00;
         d11_q <= 8'h00;
      end else if (issue_q) begin
         case (issue_idx_q)
            2'd0:    d00_q <= bus.rd_data;
            2'd1:    d01_q <= bus.rd_data;
            2'd2:    d10_q <= bus.rd_data;
            default: d11_q <= bus.rd_data;
         endcase
      end
   end
endmodule

// File: tb/tb_maxpool_ctrl.sv
// Scoreboard bench for maxpool_ctrl: SRAM and arbiter models plus a window-level
// reference that predicts every read address and every result write.
`timescale 1ns/1ps
module tb_maxpool_ctrl;
   localparam int unsigned ADDR_W = 12;
   localparam int unsigned DIM_W  = 8;

   typedef struct packed {
      logic [11:0] a;
      logic [7:0]  d;
   } wr_t;

   logic clk = 1'b0;
   logic RSTn = 1'b0;

   maxpool_ctrl_if #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) bus ();

   maxpool_ctrl #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
      .clk  (clk),
      .RSTn (RSTn),
      .bus  (bus)
   );

   initial forever #5 clk = ~clk;

   logic [7:0]  mem [4096];
   logic [11:0] exp_rd_q [$];
   wr_t         exp_wr_q [$];
   int          n_tests = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          stall_cnt = 0;
   int          gnt_mode = 0;
   int          stall_left = 0;
   logic [11:0] stall_addr = '0;
   bit          hold_chk = 1'b0;
   logic [11:0] hold_addr = '0;

   task automatic check(input string nm, input int act, input int req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
      end
   endtask

   task automatic fail_now(input string nm);
      n_tests++;
      n_fail++;
      $display("FAIL %s: got unexpected event, required none", nm);
   endtask

   // Window reduction as defined for MaxOf4, plus the optional fused ReLU
   function automatic logic [7:0] ref_pool(input logic [7:0] b00, b01, b10, b11);
      logic [7:0] top, bot, m;
      top = (b00[6:0] > b01[6:0]) ? b00 : b01;
      bot = (b10[6:0] > b11[6:0]) ? b10 : b11;
      m   = (top > bot) ? top : bot;
`ifdef MAXPOOL_RELU_EN
      if (m[7]) m = 8'h00;
`endif
      return m;
   endfunction

   task automatic build_exp(input int w, h, input logic [11:0] ib, ob, output int n);
      logic [11:0] a0, a1, a2, a3;
      wr_t e;
      n = 0;
      for (int r = 0; r + 1 < h; r += 2) begin
         for (int c = 0; c + 1 < w; c += 2) begin
            a0 = ib + 12'(r * w + c);
            a1 = ib + 12'(r * w + c + 1);
            a2 = ib + 12'((r + 1) * w + c);
            a3 = ib + 12'((r + 1) * w + c + 1);
            exp_rd_q.push_back(a0);
            exp_rd_q.push_back(a1);
            exp_rd_q.push_back(a2);
            exp_rd_q.push_back(a3);
            e.a = ob + 12'(n);
            e.d = ref_pool(mem[a0], mem[a1], mem[a2], mem[a3]);
            exp_wr_q.push_back(e);
            n++;
         end
      end
   endtask

   // 4x4 map of bytes 0..15 at 0x000, results at 0x100: window k reads base..base+5
   task automatic push_4x4();
      int b;
      wr_t e;
      for (int k = 0; k < 4; k++) begin
         b = (k / 2) * 8 + (k % 2) * 2;
         exp_rd_q.push_back(12'(b));
         exp_rd_q.push_back(12'(b + 1));
         exp_rd_q.push_back(12'(b + 4));
         exp_rd_q.push_back(12'(b + 5));
         e.a = 12'h100 + 12'(k);
         e.d = 8'(b + 5);
         exp_wr_q.push_back(e);
      end
   endtask

   task automatic pulse_start(input int w, h, input logic [11:0] ib, ob);
      @(posedge clk); #1;
      bus.start    = 1'b1;
      bus.map_w    = 8'(w);
      bus.map_h    = 8'(h);
      bus.in_base  = ib;
      bus.out_base = ob;
   endtask

   task automatic go(input int w, h, input logic [11:0] ib, ob, input int nwin);
      int t0, sb;
      bit got;
      pulse_start(w, h, ib, ob);
      t0 = cyc;
      sb = stall_cnt;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("busy_rise", bus.busy, (nwin > 0) ? 1 : 0);
      got = 1'b0;
      for (int i = 0; i < 3000 && !got; i++) begin
         @(negedge clk);
         if (bus.done) got = 1'b1;
      end
      if (!got) begin
         fail_now("done_timeout");
      end else begin
         check("done_cycle", cyc - t0, 6 * nwin + 1 + stall_cnt - sb);
         check("busy_at_done", bus.busy, 0);
      end
      @(negedge clk);
      check("done_pulse", bus.done, 0);
      check("reads_left", exp_rd_q.size(), 0);
      check("writes_left", exp_wr_q.size(), 0);
      exp_rd_q.delete();
      exp_wr_q.delete();
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Arbiter: full, random or a scripted stall on one address
   initial begin
      bus.rd_gnt = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (gnt_mode == 1) begin
            bus.rd_gnt = ($urandom_range(99) < 70);
         end else if (gnt_mode == 2 && bus.rd_req && bus.rd_addr == stall_addr
                      && stall_left > 0) begin
            bus.rd_gnt = 1'b0;
            stall_left--;
         end else begin
            bus.rd_gnt = 1'b1;
         end
      end
   end

   // SRAM: data for an issued read is presented during the following cycle
   initial begin
      bit          iss;
      logic [11:0] a;
      bus.rd_data = 8'h00;
      forever begin
         @(negedge clk);
         iss = bus.rd_req & bus.rd_gnt;
         a   = bus.rd_addr;
         @(posedge clk); #1;
         if (iss) bus.rd_data = mem[a];
      end
   end

   // Monitor: pops the scoreboard on every issued read and every write
   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         if (!RSTn) begin
            hold_chk = 1'b0;
         end else begin
            if (hold_chk) begin
               check("rd_addr_hold", {bus.rd_req, bus.rd_addr}, {1'b1, hold_addr});
               hold_chk = 1'b0;
            end
            if (bus.rd_req && bus.rd_gnt) begin
               if (exp_rd_q.size() == 0) fail_now("unexpected_read");
               else check("rd_addr", bus.rd_addr, exp_rd_q.pop_front());
            end else if (bus.rd_req) begin
               stall_cnt++;
               hold_chk  = 1'b1;
               hold_addr = bus.rd_addr;
            end
            if (bus.wr_en) begin
               if (exp_wr_q.size() == 0) begin
                  fail_now("unexpected_write");
               end else begin
                  e = exp_wr_q.pop_front();
                  check("wr_addr", bus.wr_addr, e.a);
                  check("wr_data", bus.wr_data, e.d);
               end
            end
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL global_timeout: got no finish, required finish");
      $fatal(1, "timeout");
   end

   initial begin
      int  n, sb0;
      bit  got;
      wr_t e;
      bus.start = 1'b0;
      bus.map_w = '0;
      bus.map_h = '0;
      bus.in_base = '0;
      bus.out_base = '0;
      for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
      repeat (3) @(posedge clk);
      #1;
      check("rst_ctl", {bus.rd_req, bus.wr_en, bus.busy, bus.done}, 0);
      check("rst_addr", {bus.rd_addr, bus.wr_addr}, 0);
      check("rst_data", bus.wr_data, 0);
      RSTn = 1'b1;

      // 4x4 ramp, full grant: 0x05 0x07 0x0D 0x0F, done at cycle 25
      for (int i = 0; i < 16; i++) mem[i] = 8'(i);
      push_4x4();
      go(4, 4, 12'h000, 12'h100, 4);

      // Tie-breaking / ReLU window
      mem[12'h200] = 8'h85; mem[12'h201] = 8'h03; mem[12'h202] = 8'h10; mem[12'h203] = 8'h01;
      for (int i = 0; i < 4; i++) exp_rd_q.push_back(12'h200 + 12'(i));
      e.a = 12'h300;
`ifdef MAXPOOL_RELU_EN
      e.d = 8'h00;
`else
      e.d = 8'h85;
`endif
      exp_wr_q.push_back(e);
      go(2, 2, 12'h200, 12'h300, 1);

      // 5x3: two windows, column 4 and row 2 never read
      build_exp(5, 3, 12'h040, 12'h180, n);
      go(5, 3, 12'h040, 12'h180, n);

      // Grant low for 3 cycles during RD2 of the first window
      gnt_mode = 2;
      stall_addr = 12'h004;
      stall_left = 3;
      sb0 = stall_cnt;
      push_4x4();
      go(4, 4, 12'h000, 12'h100, 4);
      check("rd2_stall_cycles", stall_cnt - sb0, 3);
      gnt_mode = 0;

      // Zero-window maps
      go(1, 4, 12'h010, 12'h100, 0);
      go(6, 1, 12'h010, 12'h100, 0);
      go(0, 0, 12'h010, 12'h100, 0);

      // Reset during the second window, then a clean rerun
      push_4x4();
      pulse_start(4, 4, 12'h000, 12'h100);
      @(posedge clk); #1;
      bus.start = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (bus.wr_en) got = 1'b1;
      end
      if (!got) fail_now("first_write_timeout");
      @(posedge clk);
      @(posedge clk); #1;
      RSTn = 1'b0;
      #1;
      check("midrst_ctl", {bus.rd_req, bus.wr_en, bus.busy, bus.done}, 0);
      check("midrst_addr", {bus.rd_addr, bus.wr_addr}, 0);
      check("midrst_data", bus.wr_data, 0);
      exp_rd_q.delete();
      exp_wr_q.delete();
      repeat (2) @(posedge clk);
      #1;
      RSTn = 1'b1;
      @(negedge clk);
      check("idle_after_rst", {bus.busy, bus.wr_en, bus.rd_req}, 0);
      push_4x4();
      go(4, 4, 12'h000, 12'h100, 4);

      // Randomized maps, bases (including address wrap) and grant patterns
      for (int t = 0; t < 16; t++) begin
         int w, h;
         logic [11:0] ib, ob;
         for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
         w  = $urandom_range(0, 11);
         h  = $urandom_range(0, 9);
         ib = (t % 4 == 0) ? 12'hFF0 : 12'($urandom);
         ob = (t % 5 == 0) ? 12'hFFE : 12'($urandom);
         gnt_mode = $urandom_range(0, 1);
         build_exp(w, h, ib, ob, n);
         go(w, h, ib, ob, n);
      end
      gnt_mode = 0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
